// File: rtl/ula_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter: opcode
// encodings, datapath width and the arbiter FSM state type.
package ula_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;
    localparam logic [3:0] OP_SLL = 4'b1110;
    localparam logic [3:0] OP_SRL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ula.sv
// Combinational 32-bit ALU. Unknown opcodes fall back to ADD; shifts use
// the whole In1 as the amount, so any amount of 32 or more clears the result.
module ula
    import ula_pkg::*;
(
    input  logic [3:0]        opcode_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic [DATA_W-1:0] in2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_flag_o
);

    logic shift_ovf;

    assign shift_ovf = |in1_i[DATA_W-1:5];

    always_comb begin
        result_o = '0;
        case (opcode_i)
            OP_AND:  result_o = in1_i & in2_i;
            OP_OR:   result_o = in1_i | in2_i;
            OP_ADD:  result_o = in1_i + in2_i;
            OP_SUB:  result_o = in1_i - in2_i;
            OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, (in1_i < in2_i)};
            OP_NOR:  result_o = ~(in1_i | in2_i);
            OP_XOR:  result_o = in1_i ^ in2_i;
            OP_SLL:  result_o = shift_ovf ? '0 : (in2_i << in1_i[4:0]);
            OP_SRL:  result_o = shift_ovf ? '0 : (in2_i >> in1_i[4:0]);
            default: result_o = in1_i + in2_i;
        endcase
    end

    assign zero_flag_o = (result_o == '0);

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin sharing of one ula between two requesters, one operation in
// flight. Define ULA_ARB_STATS_EN to add saturating per-requester grant counters.
module ula_arbiter
    import ula_pkg::*;
`ifdef ULA_ARB_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req_op0,
    input  logic [3:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero
`ifdef ULA_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              grant;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              zero_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if ((req_valid != 2'b00) && !reset) begin
                    req_ready[grant] = 1'b1;
                    owner_d          = grant;
                    last_d           = grant;
                    state_d          = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Datapath registers carry no reset; the outputs are masked outside RESP.
    always_ff @(posedge clk) begin
        if (req_ready != 2'b00) begin
            op_q <= grant ? req_op1 : req_op0;
            a_q  <= grant ? req_a1  : req_a0;
            b_q  <= grant ? req_b1  : req_b0;
        end
        if (state_q == EXEC) begin
            res_q  <= alu_res;
            zero_q <= alu_zero;
        end
    end

    ula u_ula (
        .opcode_i    (op_q),
        .in1_i       (a_q),
        .in2_i       (b_q),
        .result_o    (alu_res),
        .zero_flag_o (alu_zero)
    );

    assign resp_result = (state_q == RESP) ? res_q : '0;
    assign resp_zero   = (state_q == RESP) ? zero_q : 1'b1;

`ifdef ULA_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req_ready[0] && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
            if (req_ready[1] && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: transaction-level model plus directed
// vectors. Define ULA_ARB_STATS_EN to build and check the grant counters.
module tb_ula_arbiter;

`ifdef ULA_ARB_STATS_EN
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
`ifdef ULA_ARB_STATS_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

    int n_cmp = 0;
    int n_err = 0;

`ifdef ULA_ARB_STATS_EN
    ula_arbiter #(.CNT_W(CW)) dut (
`else
    ula_arbiter dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_a0      (req_a0),
        .req_a1      (req_a1),
        .req_b0      (req_b0),
        .req_b1      (req_b1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
`ifdef ULA_ARB_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference ALU straight from the opcode table.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b1101: return a ^ b;
            4'b1110: return (a >= 32) ? 32'd0 : (b << a);
            4'b1111: return (a >= 32) ? 32'd0 : (b >> a);
            default: return a + b;
        endcase
    endfunction

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    // Transaction model: one pending job, its owner, and edges since accept.
    bit          m_busy;
    int          m_age;
    int          m_owner;
    int          m_last;
    int          m_g;
    logic [31:0] m_res;
    int          m_cnt0, m_cnt1;
    logic [1:0]  e_rr, e_rv;

    always_comb m_g = pick(req_valid, m_last);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_last  <= 1;
            m_owner <= 0;
            m_cnt0  <= 0;
            m_cnt1  <= 0;
        end else if (!m_busy) begin
            if (req_valid != 2'b00) begin
                m_busy  <= 1'b1;
                m_age   <= 0;
                m_owner <= m_g;
                m_last  <= m_g;
                m_res   <= (m_g == 1) ? alu_ref(req_op1, req_a1, req_b1)
                                      : alu_ref(req_op0, req_a0, req_b0);
`ifdef ULA_ARB_STATS_EN
                if (m_g == 0 && m_cnt0 < CMAX) m_cnt0 <= m_cnt0 + 1;
                if (m_g == 1 && m_cnt1 < CMAX) m_cnt1 <= m_cnt1 + 1;
`endif
            end
        end else if (m_age >= 1 && resp_ready[m_owner]) begin
            m_busy <= 1'b0;
        end else if (m_age < 2) begin
            m_age <= m_age + 1;
        end
    end

    always_comb begin
        e_rr = 2'b00;
        e_rv = 2'b00;
        if (!m_busy && req_valid != 2'b00) e_rr = (m_g == 1) ? 2'b10 : 2'b01;
        if (m_busy && m_age >= 1) e_rv = (m_owner == 1) ? 2'b10 : 2'b01;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("mdl_req_ready", {30'd0, req_ready}, {30'd0, e_rr});
            chk("mdl_resp_valid", {30'd0, resp_valid}, {30'd0, e_rv});
            chk("mdl_resp_result", resp_result, (e_rv != 2'b00) ? m_res : 32'd0);
            chk("mdl_resp_zero", {31'd0, resp_zero},
                (e_rv != 2'b00) ? {31'd0, (m_res == 32'd0)} : 32'd1);
`ifdef ULA_ARB_STATS_EN
            chk("mdl_grant_cnt0", {{(32-CW){1'b0}}, grant_cnt0}, m_cnt0);
            chk("mdl_grant_cnt1", {{(32-CW){1'b0}}, grant_cnt1}, m_cnt1);
`endif
        end
    end

    task automatic drive_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_ready(input int r, input string nm);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL %s_ready_timeout: got no req_ready required req_ready[%0d]", nm, r);
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic issue(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
        @(posedge clk); #1;
        drive_req(r, op, a, b);
        wait_ready(r, nm);
    endtask

    task automatic wait_resp(input int r, input logic [31:0] er, input logic ez, input string nm, output int lat);
        bit got = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid != 2'b00) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL %s_resp_timeout: got no resp_valid required resp_valid[%0d]", nm, r);
        end else begin
            chk({nm, "_valid"}, {30'd0, resp_valid}, (r == 1) ? 32'd2 : 32'd1);
            chk({nm, "_result"}, resp_result, er);
            chk({nm, "_zero"}, {31'd0, resp_zero}, {31'd0, ez});
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [3:0]  t_op [10] = '{4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b0111,
                               4'b1100, 4'b1101, 4'b1111, 4'b1111, 4'b0010};
    logic [31:0] t_a  [10] = '{32'hFF00FF00, 32'h00000F00, 32'd3, 32'd3, 32'hFFFFFFFF,
                               32'd0, 32'h12345678, 32'd31, 32'd32, 32'hFFFFFFFF};
    logic [31:0] t_b  [10] = '{32'h0FF00FF0, 32'h000000F0, 32'd5, 32'd5, 32'd1,
                               32'd0, 32'h12345678, 32'h80000000, 32'h80000000, 32'd1};
    logic [31:0] t_r  [10] = '{32'h0F000F00, 32'h00000FF0, 32'hFFFFFFFE, 32'd1, 32'd0,
                               32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] held;
        reset = 1'b1;
        req_valid = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        resp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1 req_valid = 2'b11;
        @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_zero", {31'd0, resp_zero}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b0;

        // Basic ADD with latency check
        resp_ready = 2'b01;
        issue(0, 4'b0010, 32'd5, 32'd7, "add");
        wait_resp(0, 32'd12, 1'b0, "add", lat);
        chk("add_latency", lat, 32'd2);

        // Round-robin ties from reset
        pulse_reset();
        resp_ready = 2'b11;
        drive_req(0, 4'b0110, 32'd9, 32'd9);
        drive_req(1, 4'b0001, 32'hF0, 32'h0F);
        @(negedge clk);
        chk("tie1_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_resp(0, 32'd0, 1'b1, "tie_sub", lat);
        wait_ready(1, "tie_or");
        wait_resp(1, 32'hFF, 1'b0, "tie_or", lat);
        @(posedge clk); #1;
        drive_req(0, 4'b0000, 32'hF0F0, 32'hFF00);
        drive_req(1, 4'b0010, 32'd1, 32'd1);
        @(negedge clk);
        chk("tie3_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_resp(0, 32'hF000, 1'b0, "tie3_and", lat);
        wait_ready(1, "tie3_add");
        wait_resp(1, 32'd2, 1'b0, "tie3_add", lat);

        // Shifts and the unknown-opcode fallback
        issue(1, 4'b1110, 32'd4, 32'd1, "sll4");
        wait_resp(1, 32'd16, 1'b0, "sll4", lat);
        issue(1, 4'b1110, 32'd40, 32'd1, "sll40");
        wait_resp(1, 32'd0, 1'b1, "sll40", lat);
        issue(0, 4'b1010, 32'd3, 32'd4, "op1010");
        wait_resp(0, 32'd7, 1'b0, "op1010", lat);

        for (int i = 0; i < 10; i++) begin
            issue(0, t_op[i], t_a[i], t_b[i], "tbl");
            wait_resp(0, t_r[i], (t_r[i] == 32'd0), $sformatf("tbl%0d", i), lat);
        end

        // Backpressure: owner holds resp_ready low, other bit high
        @(posedge clk); #1;
        resp_ready = 2'b10;
        issue(0, 4'b1101, 32'hA5A5, 32'h0F0F, "hold");
        @(posedge clk); #1;
        drive_req(1, 4'b0010, 32'd1, 32'd2);
        wait_resp(0, 32'hAAAA, 1'b0, "hold", lat);
        held = resp_result;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", {30'd0, resp_valid}, 32'd1);
            chk("hold_result", resp_result, 32'hAAAA);
            chk("hold_stable", resp_result, held);
            chk("hold_req_ready", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 2'b01;
        wait_ready(1, "after_hold");
        resp_ready = 2'b10;
        wait_resp(1, 32'd3, 1'b0, "after_hold", lat);

        // Reset while an operation is executing
        @(posedge clk); #1;
        resp_ready = 2'b11;
        issue(0, 4'b0010, 32'd1, 32'd1, "rstx");
        reset = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("rstx_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rstx_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rstx_resp_result", resp_result, 32'd0);
        chk("rstx_resp_zero", {31'd0, resp_zero}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 2'b00;
        repeat (4) begin
            @(negedge clk);
            chk("rstx_no_resp", {30'd0, resp_valid}, 32'd0);
        end
        issue(0, 4'b0110, 32'd10, 32'd3, "post_rst");
        wait_resp(0, 32'd7, 1'b0, "post_rst", lat);

`ifdef ULA_ARB_STATS_EN
        pulse_reset();
        resp_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            issue(0, 4'b0010, i, 32'd1, "cnt");
            wait_resp(0, i + 1, 1'b0, "cnt", lat);
        end
        @(negedge clk);
        chk("cnt0_sat", {{(32-CW){1'b0}}, grant_cnt0}, 32'd3);
        chk("cnt1_zero", {{(32-CW){1'b0}}, grant_cnt1}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
